// File: rtl/switch_fabric_core_if.sv
// rtl/switch_fabric_core_if.sv - select, input and output bundle for the two 5x5 steering planes
interface switch_fabric_core_if #(
    parameter int P_DATA_WIDTH     = 34,
    parameter int P_FEEDBACK_WIDTH = 3
);
    logic [4:0]                  data_sel_0, data_sel_1, data_sel_2, data_sel_3, data_sel_4;
    logic [P_DATA_WIDTH-1:0]     data_in_0, data_in_1, data_in_2, data_in_3, data_in_4;
    logic [P_DATA_WIDTH-1:0]     data_out_0, data_out_1, data_out_2, data_out_3, data_out_4;
    logic [4:0]                  fb_sel_0, fb_sel_1, fb_sel_2, fb_sel_3, fb_sel_4;
    logic [P_FEEDBACK_WIDTH-1:0] feedback_in_0, feedback_in_1, feedback_in_2, feedback_in_3, feedback_in_4;
    logic [P_FEEDBACK_WIDTH-1:0] feedback_out_0, feedback_out_1, feedback_out_2, feedback_out_3, feedback_out_4;

    modport master (
        output data_sel_0, data_sel_1, data_sel_2, data_sel_3, data_sel_4,
        output data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        input  data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        output fb_sel_0, fb_sel_1, fb_sel_2, fb_sel_3, fb_sel_4,
        output feedback_in_0, feedback_in_1, feedback_in_2, feedback_in_3, feedback_in_4,
        input  feedback_out_0, feedback_out_1, feedback_out_2, feedback_out_3, feedback_out_4
    );

    modport slave (
        input  data_sel_0, data_sel_1, data_sel_2, data_sel_3, data_sel_4,
        input  data_in_0, data_in_1, data_in_2, data_in_3, data_in_4,
        output data_out_0, data_out_1, data_out_2, data_out_3, data_out_4,
        input  fb_sel_0, fb_sel_1, fb_sel_2, fb_sel_3, fb_sel_4,
        input  feedback_in_0, feedback_in_1, feedback_in_2, feedback_in_3, feedback_in_4,
        output feedback_out_0, feedback_out_1, feedback_out_2, feedback_out_3, feedback_out_4
    );
endinterface

// File: rtl/switch_fabric_core.sv
// rtl/switch_fabric_core.sv - 5x5 data and feedback priority-mux planes; SWITCH_OUT_REG_EN adds an output register stage
module switch_fabric_core #(
    parameter int P_DATA_WIDTH     = 34,
    parameter int P_FEEDBACK_WIDTH = 3
) (
    input logic clk,
    input logic rst,
    switch_fabric_core_if.slave bus
);
    logic [4:0]                  data_sel     [5];
    logic [P_DATA_WIDTH-1:0]     data_in      [5];
    logic [P_DATA_WIDTH-1:0]     data_nxt     [5];
    logic [P_DATA_WIDTH-1:0]     data_out     [5];
    logic [4:0]                  fb_sel       [5];
    logic [P_FEEDBACK_WIDTH-1:0] feedback_in  [5];
    logic [P_FEEDBACK_WIDTH-1:0] feedback_nxt [5];
    logic [P_FEEDBACK_WIDTH-1:0] feedback_out [5];

    assign data_sel[0] = bus.data_sel_0;
    assign data_sel[1] = bus.data_sel_1;
    assign data_sel[2] = bus.data_sel_2;
    assign data_sel[3] = bus.data_sel_3;
    assign data_sel[4] = bus.data_sel_4;
    assign data_in[0]  = bus.data_in_0;
    assign data_in[1]  = bus.data_in_1;
    assign data_in[2]  = bus.data_in_2;
    assign data_in[3]  = bus.data_in_3;
    assign data_in[4]  = bus.data_in_4;
    assign fb_sel[0]   = bus.fb_sel_0;
    assign fb_sel[1]   = bus.fb_sel_1;
    assign fb_sel[2]   = bus.fb_sel_2;
    assign fb_sel[3]   = bus.fb_sel_3;
    assign fb_sel[4]   = bus.fb_sel_4;
    assign feedback_in[0] = bus.feedback_in_0;
    assign feedback_in[1] = bus.feedback_in_1;
    assign feedback_in[2] = bus.feedback_in_2;
    assign feedback_in[3] = bus.feedback_in_3;
    assign feedback_in[4] = bus.feedback_in_4;

    // Scan from the highest index down so the lowest set select bit is the last, winning assignment.
    always_comb begin
        for (int j = 0; j < 5; j++) begin
            data_nxt[j] = '0;
            for (int i = 4; i >= 0; i--) begin
                if (data_sel[j][i]) data_nxt[j] = data_in[i];
            end
        end
        for (int i = 0; i < 5; i++) begin
            feedback_nxt[i] = '0;
            for (int j = 4; j >= 0; j--) begin
                if (fb_sel[i][j]) feedback_nxt[i] = feedback_in[j];
            end
        end
    end

`ifdef SWITCH_OUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                data_out[k]     <= '0;
                feedback_out[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                data_out[k]     <= data_nxt[k];
                feedback_out[k] <= feedback_nxt[k];
            end
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            data_out[k]     = data_nxt[k];
            feedback_out[k] = feedback_nxt[k];
        end
    end
`endif

    assign bus.data_out_0 = data_out[0];
    assign bus.data_out_1 = data_out[1];
    assign bus.data_out_2 = data_out[2];
    assign bus.data_out_3 = data_out[3];
    assign bus.data_out_4 = data_out[4];
    assign bus.feedback_out_0 = feedback_out[0];
    assign bus.feedback_out_1 = feedback_out[1];
    assign bus.feedback_out_2 = feedback_out[2];
    assign bus.feedback_out_3 = feedback_out[3];
    assign bus.feedback_out_4 = feedback_out[4];
endmodule

// File: tb/tb_switch_fabric_core.sv
// tb/tb_switch_fabric_core.sv - directed self-checking bench for switch_fabric_core (either SWITCH_OUT_REG_EN build)
`timescale 1ns/100ps
module tb_switch_fabric_core;
`ifdef SWITCH_OUT_REG_EN
    localparam bit REG = 1'b1;
`else
    localparam bit REG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dsel [5];
    logic [33:0] din  [5];
    logic [33:0] dout [5];
    logic [4:0]  fsel [5];
    logic [2:0]  fin  [5];
    logic [2:0]  fout [5];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [33:0] old_d0;

    always #5 clk = ~clk;

    switch_fabric_core_if #(.P_DATA_WIDTH(34), .P_FEEDBACK_WIDTH(3)) bus ();

    switch_fabric_core #(.P_DATA_WIDTH(34), .P_FEEDBACK_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.data_sel_0 = dsel[0];
    assign bus.data_sel_1 = dsel[1];
    assign bus.data_sel_2 = dsel[2];
    assign bus.data_sel_3 = dsel[3];
    assign bus.data_sel_4 = dsel[4];
    assign bus.data_in_0  = din[0];
    assign bus.data_in_1  = din[1];
    assign bus.data_in_2  = din[2];
    assign bus.data_in_3  = din[3];
    assign bus.data_in_4  = din[4];
    assign bus.fb_sel_0   = fsel[0];
    assign bus.fb_sel_1   = fsel[1];
    assign bus.fb_sel_2   = fsel[2];
    assign bus.fb_sel_3   = fsel[3];
    assign bus.fb_sel_4   = fsel[4];
    assign bus.feedback_in_0 = fin[0];
    assign bus.feedback_in_1 = fin[1];
    assign bus.feedback_in_2 = fin[2];
    assign bus.feedback_in_3 = fin[3];
    assign bus.feedback_in_4 = fin[4];
    assign dout[0] = bus.data_out_0;
    assign dout[1] = bus.data_out_1;
    assign dout[2] = bus.data_out_2;
    assign dout[3] = bus.data_out_3;
    assign dout[4] = bus.data_out_4;
    assign fout[0] = bus.feedback_out_0;
    assign fout[1] = bus.feedback_out_1;
    assign fout[2] = bus.feedback_out_2;
    assign fout[3] = bus.feedback_out_3;
    assign fout[4] = bus.feedback_out_4;

    function automatic logic [33:0] pick_d(input logic [4:0] s);
        for (int i = 0; i < 5; i++) if (s[i]) return din[i];
        return '0;
    endfunction

    function automatic logic [2:0] pick_f(input logic [4:0] s);
        for (int j = 0; j < 5; j++) if (s[j]) return fin[j];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input bit zero);
        for (int j = 0; j < 5; j++)
            chk($sformatf("%s data_out_%0d", tag, j), dout[j], zero ? 34'd0 : pick_d(dsel[j]));
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s feedback_out_%0d", tag, i), 34'(fout[i]), zero ? 34'd0 : 34'(pick_f(fsel[i])));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dsel[i] = 5'b11111;
            fsel[i] = 5'b11111;
            din[i]  = 34'({$urandom(), $urandom()});
            fin[i]  = 3'($urandom());
        end
        step();
        step();
        check_all("reset", REG);

        // release between edges; registered outputs hold 0 until the next edge
        rst = 1'b0;
        #2;
        chk("release pre-edge data_out_0", dout[0], REG ? 34'd0 : din[0]);
        step();
        check_all("after release", 1'b0);
        chk("after release data_out_4 lowest wins", dout[4], din[0]);

        old_d0 = din[0];
        dsel[0] = 5'b00010; dsel[1] = 5'b00100; dsel[2] = 5'b01000; dsel[3] = 5'b10000; dsel[4] = 5'b00001;
        for (int i = 0; i < 5; i++) din[i] = 34'h100 + 34'(i);
        #1;
        chk("perm latency data_out_0", dout[0], REG ? old_d0 : 34'h101);
        step();
        chk("perm data_out_0", dout[0], 34'h101);
        chk("perm data_out_1", dout[1], 34'h102);
        chk("perm data_out_2", dout[2], 34'h103);
        chk("perm data_out_3", dout[3], 34'h104);
        chk("perm data_out_4", dout[4], 34'h100);

        dsel[2] = 5'b00000;
        dsel[3] = 5'b10100;
        step();
        chk("idle data_out_2", dout[2], 34'd0);
        chk("fault data_out_3", dout[3], 34'h102);
        chk("fault data_out_0 unchanged", dout[0], 34'h101);

        fsel[0] = 5'b01000; fsel[1] = 5'b01000; fsel[2] = 5'b00000; fsel[3] = 5'b00000; fsel[4] = 5'b11000;
        fin[0] = 3'd1; fin[1] = 3'd2; fin[2] = 3'd3; fin[3] = 3'd5; fin[4] = 3'd7;
        step();
        chk("fanout feedback_out_0", 34'(fout[0]), 34'd5);
        chk("fanout feedback_out_1", 34'(fout[1]), 34'd5);
        chk("fanout feedback_out_2", 34'(fout[2]), 34'd0);
        chk("fanout feedback_out_3", 34'(fout[3]), 34'd0);
        chk("fb fault feedback_out_4", 34'(fout[4]), 34'd5);

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 5; j++) dsel[j] = (k % 2 == 0) ? 5'b10000 : 5'b00001;
            step();
            chk($sformatf("indep d%0d data_out_2", k), dout[2], (k % 2 == 0) ? 34'h104 : 34'h100);
            chk($sformatf("indep d%0d feedback_out_0", k), 34'(fout[0]), 34'd5);
            chk($sformatf("indep d%0d feedback_out_4", k), 34'(fout[4]), 34'd5);
        end

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) fsel[i] = (k % 2 == 0) ? 5'b00100 : 5'b10000;
            step();
            chk($sformatf("indep f%0d feedback_out_3", k), 34'(fout[3]), (k % 2 == 0) ? 34'd3 : 34'd7);
            chk($sformatf("indep f%0d data_out_1", k), dout[1], 34'h100);
        end

        dsel[0] = 5'b00100; dsel[1] = 5'b01000; dsel[2] = 5'b00010; dsel[3] = 5'b00000; dsel[4] = 5'b00011;
        fsel[0] = 5'b00010; fsel[1] = 5'b00000; fsel[2] = 5'b10000; fsel[3] = 5'b00001; fsel[4] = 5'b01100;
        step();
        check_all("stream", 1'b0);

        #2;
        rst = 1'b1;
        #1;
        check_all("mid reset", REG);
        #2;
        rst = 1'b0;
        #1;
        chk("mid release pre-edge data_out_0", dout[0], REG ? 34'd0 : 34'h102);
        step();
        check_all("resume", 1'b0);
        chk("resume data_out_4", dout[4], 34'h100);
        chk("resume feedback_out_4", 34'(fout[4]), 34'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_fabric_core.md
# switch_fabric_core

Five-port router switch fabric with two independent 5×5 one-hot multiplexer planes.
- **Data plane:** moves flits from input ports to output ports.
- **Feedback plane:** returns downstream buffer-credit information from each output port to the input port that is routing into it.

The block sits inside the router crossbar, after switch allocation. Selects arrive already decoded, so the fabric does no arbitration of its own.

## Interface
Parameters:
- `P_DATA_WIDTH`, default 34: flit width plus valid bit(s), per port.
- `P_FEEDBACK_WIDTH`, default 3: buffer-occupancy/credit field width, per port.

Ports:
- `clk`, input, 1: single clock; all state is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `data_sel_0` … `data_sel_4`, input, 5 each:
  - `data_sel_j` chooses the source for `data_out_j`.
  - Bit i set selects `data_in_i`.
- `data_in_0` … `data_in_4`, input, `P_DATA_WIDTH` each: flit from input port i.
- `data_out_0` … `data_out_4`, output, `P_DATA_WIDTH` each: flit to output port j.
- `fb_sel_0` … `fb_sel_4`, input, 5 each:
  - `fb_sel_i` is input port i's request vector.
  - Bit j set selects `feedback_in_j`.
- `feedback_in_0` … `feedback_in_4`, input, `P_FEEDBACK_WIDTH` each: credit/status from output port j.
- `feedback_out_0` … `feedback_out_4`, output, `P_FEEDBACK_WIDTH` each: credit/status delivered to input port i.

## Operation
Data plane, for each output j:
- `data_out_j` = `data_in_i`, where i is the lowest set bit of `data_sel_j`.
- `data_sel_j` == 0 → `data_out_j` = 0 (idle output carries an all-zero flit, so its valid bit is 0).
- More than one bit set (allocator fault) → the lowest index wins. There is no OR-merge and no error flag.

Feedback plane, for each input i:
- `feedback_out_i` = `feedback_in_j`, where j is the lowest set bit of `fb_sel_i`.
- `fb_sel_i` == 0 → `feedback_out_i` = 0.
- The same priority rule as the data plane applies.

General rules:
- The planes are fully independent. `data_sel_*` never affects feedback and `fb_sel_*` never affects data.
- Several inputs may select the same output's feedback. All of them receive the same `feedback_in_j`; this fan-out is legal.
- No width conversion: each output is bit-exact with its chosen input.
- No handshake and no back-pressure. The block is a pure steering element; flow control lives in the feedback values it carries.

## Timing
With `SWITCH_OUT_REG_EN` defined:
- Every `data_out_*` and `feedback_out_*` is registered.
- Latency is exactly 1 cycle: the output in cycle n+1 reflects selects and inputs sampled at the edge ending cycle n.
- `rst` asserted: all outputs go to 0 immediately, independent of `clk`, and stay 0 while `rst` is high.
- First valid update is on the first rising edge after `rst` deasserts.
- `rst` asserted mid-transfer: the in-flight registered flit is dropped (output 0). Upstream must re-send it.
- A select change takes effect at the next edge. There is no glitch on registered outputs.

Without `SWITCH_OUT_REG_EN`:
- Outputs are combinational, with zero-cycle latency.
- `clk` and `rst` are present but unused.

## Configuration
- Macro: `SWITCH_OUT_REG_EN`.
- Defined: one output register stage on both planes, giving 1-cycle latency and async reset to 0 as above.
- Undefined: purely combinational muxes, same port list, reset has no effect.
- Selection and priority behaviour are identical in both builds.

## Test plan
Scenarios are written for the registered build (`SWITCH_OUT_REG_EN` defined).

- **Reset:** `rst`=1 with random inputs and all selects = 5'b11111 → every `data_out_*` and `feedback_out_*` = 0. Deassert `rst` → outputs follow selects from the next edge.
- **Permutation:** `data_sel_0..4` = 00010, 00100, 01000, 10000, 00001 and `data_in_i` = 0x100+i → one cycle later `data_out_0..4` = 0x101, 0x102, 0x103, 0x104, 0x100.
- **Idle and fault priority:**
  - `data_sel_2` = 0 → `data_out_2` = 0.
  - `data_sel_3` = 5'b10100 → `data_out_3` = `data_in_2`.
- **Feedback fan-out:** `fb_sel_0` = `fb_sel_1` = 5'b01000 and `feedback_in_3` = 3'd5 → `feedback_out_0` = `feedback_out_1` = 5. Other inputs, with select 0, read 0.
- **Plane independence:** toggle `data_sel_*` every cycle while `fb_sel_*` is held → `feedback_out_*` stays constant, and vice versa.
- **Reset mid-stream:** assert `rst` asynchronously between edges while flits flow → outputs go to 0 before the next edge and resume one edge after release.
